// File: rtl/clock_ctrl.sv
// Digital clock time-keeping and two-button time-set controller.
// Optional 0.5 Hz blink of the field being edited: define CLOCK_CTRL_BLINK_EN.

module clock_ctrl (
    input  logic       clk,
    input  logic       reset_,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] digOra,
    output logic [5:0] digMin,
    output logic [5:0] digSec,
    output logic [1:0] mode,
    output logic       blank_h,
    output logic       blank_m
);

    // state    | meaning
    // ST_RUN   | time advances on tick_1hz, increment button ignored
    // ST_SET_H | increment button steps the hour, time frozen
    // ST_SET_M | increment button steps the minute, time frozen
    // ST_BAD   | unreachable encoding, falls back to ST_RUN
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_SET_H = 2'b01,
        ST_SET_M = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       prev_mode;
    logic       prev_inc;
    logic       mode_edge;
    logic       inc_edge;
    logic [4:0] hour_nxt;
    logic [5:0] min_nxt;
    logic [5:0] sec_nxt;

    assign mode_edge = btn_mode & ~prev_mode;
    assign inc_edge  = btn_inc & ~prev_inc;
    assign mode      = state;

    // History flops reset high so a button held through reset gives no edge.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            prev_mode <= 1'b1;
            prev_inc  <= 1'b1;
        end else begin
            prev_mode <= btn_mode;
            prev_inc  <= btn_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state  <= ST_RUN;
            digOra <= 5'd0;
            digMin <= 6'd0;
            digSec <= 6'd0;
        end else begin
            state  <= state_nxt;
            digOra <= hour_nxt;
            digMin <= min_nxt;
            digSec <= sec_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hour_nxt  = digOra;
        min_nxt   = digMin;
        sec_nxt   = digSec;
        case (state)
            ST_RUN: begin
                if (mode_edge) begin
                    state_nxt = ST_SET_H;
                    sec_nxt   = 6'd0;
                end else if (tick_1hz) begin
                    if (digSec == 6'd59) begin
                        sec_nxt = 6'd0;
                        if (digMin == 6'd59) begin
                            min_nxt = 6'd0;
                            if (digOra == 5'd23) begin
                                hour_nxt = 5'd0;
                            end else begin
                                hour_nxt = digOra + 5'd1;
                            end
                        end else begin
                            min_nxt = digMin + 6'd1;
                        end
                    end else begin
                        sec_nxt = digSec + 6'd1;
                    end
                end
            end
            ST_SET_H: begin
                if (mode_edge) begin
                    state_nxt = ST_SET_M;
                end else if (inc_edge) begin
                    if (digOra == 5'd23) begin
                        hour_nxt = 5'd0;
                    end else begin
                        hour_nxt = digOra + 5'd1;
                    end
                end
            end
            ST_SET_M: begin
                if (mode_edge) begin
                    state_nxt = ST_RUN;
                end else if (inc_edge) begin
                    // Minute setting wraps without touching the hour.
                    if (digMin == 6'd59) begin
                        min_nxt = 6'd0;
                    end else begin
                        min_nxt = digMin + 6'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

`ifdef CLOCK_CTRL_BLINK_EN
    logic phase;
    logic phase_nxt;
    logic in_set;

    assign in_set = (state == ST_SET_H) || (state == ST_SET_M);

    always_comb begin
        phase_nxt = phase;
        if (mode_edge) begin
            phase_nxt = 1'b0;
        end else if (tick_1hz && in_set) begin
            phase_nxt = ~phase;
        end
    end

    // Blank flags are computed from next-state values so they line up with mode.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            phase   <= 1'b0;
            blank_h <= 1'b0;
            blank_m <= 1'b0;
        end else begin
            phase   <= phase_nxt;
            blank_h <= (state_nxt == ST_SET_H) & phase_nxt;
            blank_m <= (state_nxt == ST_SET_M) & phase_nxt;
        end
    end
`else
    assign blank_h = 1'b0;
    assign blank_m = 1'b0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed self-checking bench for clock_ctrl; follows CLOCK_CTRL_BLINK_EN for blink expectations.

module tb_clock_ctrl;

    logic       clk;
    logic       reset_;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] digOra;
    logic [5:0] digMin;
    logic [5:0] digSec;
    logic [1:0] mode;
    logic       blank_h;
    logic       blank_m;

    int checks = 0;
    int passed = 0;

`ifdef CLOCK_CTRL_BLINK_EN
    localparam logic BL = 1'b1;
`else
    localparam logic BL = 1'b0;
`endif

    clock_ctrl dut (
        .clk      (clk),
        .reset_   (reset_),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .digOra   (digOra),
        .digMin   (digMin),
        .digSec   (digSec),
        .mode     (mode),
        .blank_h  (blank_h),
        .blank_m  (blank_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hour"}, 32'(digOra), 32'(h));
        check({tag, ".min"},  32'(digMin), 32'(m));
        check({tag, ".sec"},  32'(digSec), 32'(s));
    endtask

    // Outputs are read 1 time unit after the edge that sampled the inputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
        end
    endtask

    task automatic pulse_mode();
        btn_mode = 1'b1;
        step();
        btn_mode = 1'b0;
        step();
    endtask

    task automatic pulse_inc(input int n);
        for (int i = 0; i < n; i++) begin
            btn_inc = 1'b1;
            step();
            btn_inc = 1'b0;
            step();
        end
    endtask

    initial begin
        reset_   = 1'b0;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        #12;
        check_time("reset", 0, 0, 0);
        check("reset.mode", 32'(mode), 0);
        check("reset.blank_h", 32'(blank_h), 0);
        check("reset.blank_m", 32'(blank_m), 0);
        @(posedge clk);
        #1 reset_ = 1'b1;
        step();

        tick(61);
        check_time("run61", 0, 1, 1);
        check("run61.mode", 32'(mode), 0);

        // Set 23:59 then count up to the midnight rollover.
        pulse_mode();
        check("enter_h.mode", 32'(mode), 1);
        check_time("enter_h", 0, 1, 0);
        pulse_inc(23);
        pulse_mode();
        check("enter_m.mode", 32'(mode), 2);
        pulse_inc(58);
        pulse_mode();
        check("back_run.mode", 32'(mode), 0);
        tick(58);
        check_time("t235958", 23, 59, 58);
        tick(1);
        check_time("t235959", 23, 59, 59);
        tick(1);
        check_time("midnight", 0, 0, 0);

        // Build 12:34:56.
        pulse_mode();
        pulse_inc(12);
        pulse_mode();
        pulse_inc(34);
        pulse_mode();
        tick(56);
        check_time("t123456", 12, 34, 56);

        pulse_mode();
        check("seth.mode", 32'(mode), 1);
        check_time("seth", 12, 34, 0);
        check("seth.blank_h0", 32'(blank_h), 0);
        pulse_inc(13);
        check_time("hour_wrap", 1, 34, 0);

        tick(1);
        check_time("seth_tick1", 1, 34, 0);
        check("blink1.blank_h", 32'(blank_h), 32'(BL));
        check("blink1.blank_m", 32'(blank_m), 0);
        tick(1);
        check_time("seth_tick2", 1, 34, 0);
        check("blink2.blank_h", 32'(blank_h), 0);
        check("blink2.blank_m", 32'(blank_m), 0);

        // Increment and tick together: increment wins, time frozen.
        btn_inc  = 1'b1;
        tick_1hz = 1'b1;
        step();
        btn_inc  = 1'b0;
        tick_1hz = 1'b0;
        step();
        check_time("inc_tick", 2, 34, 0);

        btn_inc = 1'b1;
        repeat (20) step();
        btn_inc = 1'b0;
        step();
        check_time("inc_held", 3, 34, 0);

        // Mode and increment rising together: mode wins.
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        step();
        check("mode_inc.mode", 32'(mode), 2);
        check_time("mode_inc", 3, 34, 0);
        check("mode_inc.blank_h", 32'(blank_h), 0);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step();

        pulse_inc(30);
        check_time("min_wrap", 3, 4, 0);
        pulse_mode();
        check("resume.mode", 32'(mode), 0);
        check_time("resume", 3, 4, 0);
        tick(1);
        check_time("resume_tick", 3, 4, 1);

        tick(58);
        check_time("t030459", 3, 4, 59);
        btn_mode = 1'b1;
        tick_1hz = 1'b1;
        step();
        btn_mode = 1'b0;
        tick_1hz = 1'b0;
        check("mode_tick.mode", 32'(mode), 1);
        check_time("mode_tick", 3, 4, 0);
        step();

        pulse_mode();
        check("setm2.mode", 32'(mode), 2);
        tick(1);
        check("setm_blink.blank_m", 32'(blank_m), 32'(BL));
        check("setm_blink.blank_h", 32'(blank_h), 0);
        check_time("setm_tick", 3, 4, 0);

        // Asynchronous reset mid-SET_M with both buttons held through release.
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        reset_   = 1'b0;
        #1;
        check_time("async_rst", 0, 0, 0);
        check("async_rst.mode", 32'(mode), 0);
        check("async_rst.blank_m", 32'(blank_m), 0);
        @(negedge clk);
        reset_ = 1'b1;
        step();
        step();
        step();
        check("held_rst.mode", 32'(mode), 0);
        check_time("held_rst", 0, 0, 0);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        step();
        check("held_rel.mode", 32'(mode), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Time-keeping and time-set controller for the digital clock. Holds the seconds, minutes and hours counters, advances them on a 1 Hz tick, and runs a two-button set-time state machine. `digOra` feeds the hour divide/mod digit splitter directly. `digMin` and `digSec` feed the equivalent minute and second splitters.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset_`  in  1  asynchronous, active-low reset.
- `tick_1hz`  in  1  one-cycle pulse, once per second, synchronous to `clk`.
- `btn_mode`  in  1  mode button, debounced level, active-high.
- `btn_inc`  in  1  increment button, debounced level, active-high.
- `digOra`  out  5  hours, 0–23, registered.
- `digMin`  out  6  minutes, 0–59, registered.
- `digSec`  out  6  seconds, 0–59, registered.
- `mode`  out  2  current state: 00 RUN, 01 SET_H, 10 SET_M.
- `blank_h`  out  1  blank the hour digits (blink).
- `blank_m`  out  1  blank the minute digits (blink).

## Operation
- Reset values:
  - `digOra`, `digMin` and `digSec` are 0.
  - `mode` is RUN.
  - `blank_h` and `blank_m` are 0.
  - The blink phase is 0.
  - Both button-history flops reset to 1, so a button held through reset release produces no edge.
- Edge detection:
  - `mode_edge` = `btn_mode` & ~prev_mode.
  - `inc_edge` = `btn_inc` & ~prev_inc.
  - prev_* register the raw level every cycle.
- State machine: `mode_edge` steps the state RUN → SET_H → SET_M → RUN. Encoding 11 is unreachable; if it is ever entered, it returns to RUN on the next cycle.
- RUN:
  - `tick_1hz` increments `digSec`.
  - 59 → 0 on `digSec` carries into `digMin`.
  - 59 → 0 on `digMin` carries into `digOra`.
  - `digOra` wraps 23 → 0, so 23:59:59 + tick = 00:00:00.
  - All carries resolve in one cycle.
  - `inc_edge` is ignored.
- Entering SET_H (from RUN): `digSec` is cleared to 0 in the same update.
- SET_H: `inc_edge` increments `digOra`, wrapping 23 → 0. `digMin` and `digSec` are held.
- SET_M: `inc_edge` increments `digMin`, wrapping 59 → 0, with no carry into the hour. `digOra` and `digSec` are held.
- Ticks in SET_H and SET_M do not change the time. They affect only the blink phase.
- SET_M → RUN: counting resumes from the next tick, starting at second 0.
- Priority within one cycle:
  - `mode_edge` beats `inc_edge`; the increment is discarded.
  - In RUN, `mode_edge` beats `tick_1hz`; the tick is dropped and the seconds are cleared.
  - `inc_edge` together with `tick_1hz` in a SET state: the increment is applied and the time does not advance.
- Arithmetic:
  - Compare-and-wrap only; no modulo operators.
  - Counter widths are exact (5/6/6 bits).
  - Values outside the legal range are unreachable from reset.
- Reset asserted mid-operation returns every flop to its reset value immediately, independent of `clk`.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- An event sampled at clock edge N appears on the outputs after edge N. This covers a tick, a button edge (the first edge that samples the level high), and a state change.
- Button to count latency: 1 cycle.
- Holding a button high produces exactly one edge. A further edge requires the level to go low for at least one cycle.
- The digit splitter adds 1 further cycle, so time appears on the display 2 cycles after the tick.
- Back-to-back button pulses (1 cycle high, 1 cycle low) are each counted.

## Configuration
- Macro: `CLOCK_CTRL_BLINK_EN`.
- Defined:
  - The blink phase flop toggles on each `tick_1hz` while in SET_H or SET_M.
  - The phase is cleared to 0 on every `mode_edge`.
  - `blank_h` = (state == SET_H) & phase.
  - `blank_m` = (state == SET_M) & phase.
  - Both blank outputs are registered.
  - Result: the field being edited blinks at 0.5 Hz.
- Not defined: no phase flop; `blank_h` and `blank_m` are tied to 0. All other behaviour is unchanged.

## Test plan
- Reset then 61 ticks in RUN → outputs read 00:01:01 and `mode`=00. Starting at 23:59:58, 2 ticks → 00:00:00.
- `btn_mode` pulse at 12:34:56 → `mode`=01 and time 12:34:00. Then 13 `btn_inc` pulses → `digOra`=1 (12+13 wraps through 23 → 0). Ticks during SET_H leave the time unchanged.
- Two further mode pulses (to SET_M, then RUN), with 30 `btn_inc` pulses in SET_M starting from minute 34 → minute 4 and hour unchanged. In RUN, the first tick → second 1.
- `btn_mode` and `btn_inc` rising in the same cycle in SET_H → state advances to SET_M and hour unchanged. `btn_mode` rising in RUN on the same cycle as `tick_1hz` → SET_H with seconds 0 and no tick carry.
- `btn_inc` held high for 20 cycles in SET_H → exactly +1. Button held through reset release → no edge, state stays RUN.
- Blink, with `CLOCK_CTRL_BLINK_EN` defined: in SET_H, successive ticks toggle `blank_h` 0 → 1 → 0 while `blank_m` stays 0. Without the macro, both outputs stay 0. `reset_` asserted mid-SET_M → immediate 00:00:00 and RUN.
